// File: rtl/led_pio_pkg.sv
// rtl/led_pio_pkg.sv - register map and sizing helpers for the LED output PIO
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_PWM_MASK = 3'd2;
  localparam logic [2:0] ADDR_DUTY     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_PULSE    = 3'd6;

  localparam int DUTY_W = 8;

  // Bits needed to hold 0..max_val; never less than one so degenerate counters still elaborate.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_pio_pwm_gen.sv
// rtl/led_pio_pwm_gen.sv - shared PWM dimmer: prescaler, 8-bit phase and period-aligned duty shadow
module led_pio_pwm_gen
  import led_pio_pkg::*;
#(
  parameter int PWM_DIV = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_on
);

  localparam int              PRE_W    = cnt_w(PWM_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0]  prescaler;
  logic [DUTY_W-1:0] phase;
  logic [DUTY_W-1:0] duty_active;
  logic              tick;

  assign tick = (prescaler == PRE_LAST);

  // Prescaler runs 0..PWM_DIV-1 and restarts after its terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Phase steps once per tick and wraps 255->0; duty is sampled only on that wrap so a period never splits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= '0;
      duty_active <= '0;
    end else if (tick) begin
      phase <= phase + DUTY_W'(1);
      if (phase == {DUTY_W{1'b1}}) begin
        duty_active <= duty;
      end
    end
  end

  assign pwm_on = (phase < duty_active);

endmodule

// File: rtl/led_pio_out.sv
// rtl/led_pio_out.sv - Avalon-MM output PIO with set/clear, PWM dimming and one-shot pulse inversion
module led_pio_out
  import led_pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int RESET_VALUE  = 0,
  parameter int PWM_DIV      = 256,
  parameter int PULSE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam int               PC_W    = cnt_w(PULSE_CYCLES);
  localparam logic [PC_W-1:0]  PC_LOAD = PC_W'(PULSE_CYCLES);

  logic [WIDTH-1:0]  data_reg;
  logic [WIDTH-1:0]  pwm_mask;
  logic [DUTY_W-1:0] duty;
  logic [WIDTH-1:0]  pulse_active;
  logic [PC_W-1:0]   pulse_cnt;
  logic [WIDTH-1:0]  rd_next;
  logic [WIDTH-1:0]  out_next;
  logic              wr_en;
  logic              pulse_load;
  logic              pwm_on;

  assign wr_en      = chipselect && !write_n;
  assign pulse_load = wr_en && (address == ADDR_PULSE) && (writedata != '0);

  led_pio_pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .duty   (duty),
    .pwm_on (pwm_on)
  );

  // CPU-visible registers; OUTSET/OUTCLEAR give read-free atomic bit updates to DATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= RST_VAL;
      pwm_mask <= '0;
      duty     <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_reg <= writedata;
        ADDR_PWM_MASK: pwm_mask <= writedata;
        ADDR_DUTY:     duty     <= DUTY_W'(writedata);
        ADDR_OUTSET:   data_reg <= data_reg | writedata;
        ADDR_OUTCLEAR: data_reg <= data_reg & ~writedata;
        default:       ;
      endcase
    end
  end

  // One-shot inverter: a nonzero write merges bits and restarts the full length, even on the expiry clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_cnt    <= '0;
      pulse_active <= '0;
    end else if (pulse_load) begin
      pulse_cnt    <= PC_LOAD;
      pulse_active <= pulse_active | writedata;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - PC_W'(1);
      if (pulse_cnt == PC_W'(1)) begin
        pulse_active <= '0;
      end
    end
  end

  // Read mux; write-only and reserved offsets read as zero.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next = data_reg;
      ADDR_PWM_MASK: rd_next = pwm_mask;
      ADDR_DUTY:     rd_next = WIDTH'(duty);
      ADDR_PULSE:    rd_next = pulse_active;
      default:       rd_next = '0;
    endcase
  end

  assign out_next = (data_reg & (~pwm_mask | {WIDTH{pwm_on}})) ^ pulse_active;

  // Registered read data and pin drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      out_port <= RST_VAL;
    end else begin
      readdata <= rd_next;
      out_port <= out_next;
    end
  end

endmodule

// File: tb/tb_led_pio_out.sv
// tb/tb_led_pio_out.sv - self-checking bench for led_pio_out
module tb_led_pio_out;

  localparam int W      = 8;
  localparam int RV     = 8'h3C;
  localparam int DIV    = 2;
  localparam int PC     = 10;
  localparam int PERIOD = DIV * 256;

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic [2:0]   address    = 3'd0;
  logic         chipselect = 1'b0;
  logic         write_n    = 1'b1;
  logic [W-1:0] writedata  = '0;
  logic [W-1:0] readdata;
  logic [W-1:0] out_port;

  int total = 0;
  int bad   = 0;

  // Reference model: time-based view (edges since reset, pulse deadline, arithmetic phase).
  logic [7:0] m_data, m_mask, m_duty, m_dact, m_bits, m_out, m_rd;
  int         m_n, m_end;

  typedef struct {
    logic [2:0] addr;
    logic       wr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  led_pio_out #(
    .WIDTH        (W),
    .RESET_VALUE  (RV),
    .PWM_DIV      (DIV),
    .PULSE_CYCLES (PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, m_n);
    end
  endtask

  function automatic void model_reset();
    m_data = 8'(RV); m_mask = 8'h00; m_duty = 8'h00; m_dact = 8'h00;
    m_bits = 8'h00;  m_out  = 8'(RV); m_rd  = 8'h00;
    m_n = 0; m_end = 0;
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] a, input logic [7:0] p);
    case (a)
      3'd0:    return m_data;
      3'd2:    return m_mask;
      3'd3:    return m_duty;
      3'd6:    return p;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    logic [7:0] p_old;
    logic       pwm_old;
    @(posedge clk);
    m_n++;
    p_old   = (m_n - 1 < m_end) ? m_bits : 8'h00;
    pwm_old = ((((m_n - 1) / DIV) % 256) < int'(m_dact));
    m_out   = (m_data & (~m_mask | {8{pwm_old}})) ^ p_old;
    m_rd    = model_read(address, p_old);
    if (m_n % PERIOD == 0) m_dact = m_duty;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = writedata;
        3'd2: m_mask = writedata;
        3'd3: m_duty = writedata;
        3'd4: m_data = m_data | writedata;
        3'd5: m_data = m_data & ~writedata;
        3'd6: if (writedata != 8'h00) begin
                m_bits = p_old | writedata;
                m_end  = m_n + PC;
              end
        default: ;
      endcase
    end
    #1;
    check("model_out", out_port, m_out);
    check("model_rd", readdata, m_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_reset();
    chipselect = 1'b0; write_n = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rst_out", out_port, 8'(RV));
    check("rst_rd", readdata, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int hi;
    int upper_bad;

    model_reset();
    do_reset();

    // Register map: data path, set/clear, reserved and write-only offsets.
    vecs[0]  = '{3'd0, 1'b1, 8'hA5, 8'h3C, 8'h3C};
    vecs[1]  = '{3'd0, 1'b0, 8'h00, 8'hA5, 8'hA5};
    vecs[2]  = '{3'd4, 1'b1, 8'h0F, 8'h00, 8'hA5};
    vecs[3]  = '{3'd0, 1'b0, 8'h00, 8'hAF, 8'hAF};
    vecs[4]  = '{3'd5, 1'b1, 8'hA0, 8'h00, 8'hAF};
    vecs[5]  = '{3'd0, 1'b0, 8'h00, 8'h0F, 8'h0F};
    vecs[6]  = '{3'd1, 1'b1, 8'hFF, 8'h00, 8'h0F};
    vecs[7]  = '{3'd7, 1'b1, 8'hFF, 8'h00, 8'h0F};
    vecs[8]  = '{3'd1, 1'b0, 8'h00, 8'h00, 8'h0F};
    vecs[9]  = '{3'd7, 1'b0, 8'h00, 8'h00, 8'h0F};
    vecs[10] = '{3'd4, 1'b0, 8'h00, 8'h00, 8'h0F};
    vecs[11] = '{3'd5, 1'b0, 8'h00, 8'h00, 8'h0F};
    vecs[12] = '{3'd0, 1'b0, 8'h00, 8'h0F, 8'h0F};
    vecs[13] = '{3'd2, 1'b1, 8'h00, 8'h00, 8'h0F};
    vecs[14] = '{3'd3, 1'b1, 8'hC8, 8'h00, 8'h0F};
    vecs[15] = '{3'd3, 1'b0, 8'h00, 8'hC8, 8'h0F};
    vecs[16] = '{3'd6, 1'b0, 8'h00, 8'h00, 8'h0F};
    for (int i = 0; i < 17; i++) begin
      address = vecs[i].addr; writedata = vecs[i].wd;
      chipselect = vecs[i].wr; write_n = !vecs[i].wr;
      tick();
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), out_port, vecs[i].exp_out);
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Single pulse on 0x03: exactly PC clocks on the pins and in addr 6.
    wr(3'd0, 8'h00);
    wr(3'd6, 8'h03);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("p_out", out_port, (k <= 10) ? 8'h03 : 8'h00);
      check("p_rd", readdata, (k <= 10) ? 8'h03 : 8'h00);
    end

    // Retrigger with 0x04 five clocks in.
    wr(3'd6, 8'h03);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rt_pre", out_port, 8'h03);
    end
    wr(3'd6, 8'h04);
    check("rt_edge", out_port, 8'h03);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("rt_out", out_port, (k <= 10) ? 8'h07 : 8'h00);
    end

    // New pulse written on the very clock the old one expires.
    wr(3'd6, 8'h01);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("ex_pre", out_port, 8'h01);
    end
    wr(3'd6, 8'h02);
    check("ex_edge", out_port, 8'h01);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("ex_out", out_port, (k <= 10) ? 8'h03 : 8'h00);
      check("ex_rd", readdata, (k <= 10) ? 8'h03 : 8'h00);
    end

    // Reset while pins toggle, then every offset reads back its reset value.
    wr(3'd0, 8'h55); wr(3'd2, 8'hFF); wr(3'd3, 8'h80); wr(3'd6, 8'h0F);
    for (int k = 0; k < 600; k++) tick();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      tick();
      check($sformatf("rst_read%0d", a), readdata, (a == 0) ? 8'(RV) : 8'h00);
      check("rst_hold_out", out_port, 8'(RV));
    end

    // PWM on bit0 with DUTY=64, then DUTY=0 written mid-period.
    do_reset();
    wr(3'd0, 8'hFF); wr(3'd2, 8'h01); wr(3'd3, 8'h40);
    hi = 0; upper_bad = 0;
    while (m_n < PERIOD) begin
      tick();
      hi += int'(out_port[0]);
      if (out_port[7:1] != 7'h7F) upper_bad++;
    end
    check("pwm_prewrap_hi", hi, 0);
    hi = 0;
    while (m_n < 2 * PERIOD) begin
      tick();
      hi += int'(out_port[0]);
      if (out_port[7:1] != 7'h7F) upper_bad++;
    end
    check("pwm_period_hi", hi, 128);
    check("pwm_upper_bits", upper_bad, 0);
    while (m_n < 1123) tick();
    wr(3'd3, 8'h00);
    hi = 0;
    while (m_n < 3 * PERIOD) begin
      tick();
      hi += int'(out_port[0]);
    end
    check("pwm_tail_hi", hi, 28);
    hi = 0;
    while (m_n < 4 * PERIOD) begin
      tick();
      hi += int'(out_port[0]);
    end
    check("pwm_zero_hi", hi, 0);

    // Random bus traffic against the model, with one reset in the middle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
